// File: rtl/memory_access_unit_pkg.sv
// Shared constants for the processor slice: default widths, control-unit
// state codes and the memory access unit state codes.
package memory_access_unit_pkg;

    // Default datapath and address width of the processor.
    localparam int WORD_DEFAULT     = 16;
    // Default number of ACCESS cycles before an access is abandoned.
    localparam int MAX_WAIT_DEFAULT = 8;

    // Control-unit sequencing states.
    typedef enum logic [2:0] {
        CU_FETCH     = 3'd0,
        CU_DECODE    = 3'd1,
        CU_EXECUTE   = 3'd2,
        CU_MEMORY    = 3'd3,
        CU_WRITEBACK = 3'd4
    } cu_state_e;

    // Memory access unit states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mau_state_e;

endpackage

// File: rtl/memory_access_unit_mem_wait_counter.sv
// Wait-cycle counter for the memory access unit. Cleared outside ACCESS,
// counts ACCESS cycles, and flags the last allowed cycle (MAX_WAIT-1).
module memory_access_unit_mem_wait_counter #(
    parameter int MAX_WAIT = 8,
    parameter int CW       = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] count;

    // Count enabled cycles; reset and clear both return to zero.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/memory_access_unit.sv
// Memory access unit: turns a single-cycle read/write request from the
// control unit into a held memory strobe, waits for mem_ready (bounded by
// MAX_WAIT cycles), captures read data into ir or mdr, and reports done/err.
//
// Request handshake: the control unit raises exactly one of req_read or
// req_write and holds it until done. The request is accepted on the first
// rising edge where the unit is IDLE; while busy the request lines are not
// looked at. On the memory side, the strobe stays high with a stable address
// and write data until mem_ready is sampled high (or the wait budget runs out).
module memory_access_unit
    import memory_access_unit_pkg::*;
#(
    parameter int WORD     = WORD_DEFAULT,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_read,
    input  logic            req_write,
    input  logic            i_or_d,
    input  logic [WORD-1:0] pc_addr,
    input  logic [WORD-1:0] alu_addr,
    input  logic [WORD-1:0] wr_data,
    output logic [WORD-1:0] mem_addr,
    output logic [WORD-1:0] mem_wdata,
    output logic            mem_read,
    output logic            mem_write,
    input  logic [WORD-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [WORD-1:0] ir,
    output logic [WORD-1:0] mdr,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [WORD-1:0] fetch_count,
    output logic [1:0]      dbg_state
);

    mau_state_e state, state_next;

    logic is_write;      // latched request type
    logic is_data;       // latched i_or_d
    logic timeout;       // access ended without mem_ready
    logic conflict_err;  // both requests seen together in IDLE
    logic wait_tc;

    logic start, conflict, capture, expire;

    assign start    = (state == IDLE)   && (req_read ^ req_write);
    assign conflict = (state == IDLE)   && req_read && req_write;
    assign capture  = (state == ACCESS) && mem_ready;
    assign expire   = (state == ACCESS) && !mem_ready && wait_tc;

    assign dbg_state = state;

    memory_access_unit_mem_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_mem_wait_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state != ACCESS),
        .en      (state == ACCESS),
        .tc      (wait_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and strobe/status decode; strobes exist only in ACCESS so
    // they can never overlap and drop as soon as the state leaves ACCESS.
    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = conflict_err;
        case (state)
            IDLE: begin
                if (start) state_next = ACCESS;
            end
            ACCESS: begin
                busy      = 1'b1;
                mem_read  = !is_write;
                mem_write = is_write;
                if (mem_ready || wait_tc) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                err        = conflict_err | timeout;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latching, read-data capture, fetch counting and error flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_addr     <= '0;
            mem_wdata    <= '0;
            is_write     <= 1'b0;
            is_data      <= 1'b0;
            timeout      <= 1'b0;
            conflict_err <= 1'b0;
            ir           <= '0;
            mdr          <= '0;
            fetch_count  <= '0;
        end else begin
            conflict_err <= conflict;
            if (start) begin
                mem_addr  <= i_or_d ? alu_addr : pc_addr;
                mem_wdata <= wr_data;
                is_write  <= req_write;
                is_data   <= i_or_d;
                timeout   <= 1'b0;
            end
            if (capture && !is_write) begin
                if (is_data) begin
                    mdr <= mem_rdata;
                end else begin
                    ir          <= mem_rdata;
                    fetch_count <= fetch_count + WORD'(1);
                end
            end
            if (expire) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule
